// File: rtl/mii_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mii_tx_framer
// Purpose  : Transmit-side MII framer. Wraps a MAC byte stream with preamble
//            and SFD, zero-pads to a minimum payload, appends the CRC-32 FCS
//            and enforces the inter-frame gap on txen/txd.
// Revision : 1.0 - initial release
// ============================================================================
module mii_tx_framer #(
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic       txc,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       txen,
  output logic [3:0] txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  // Counter must hold the preamble index (0..15) and the IFG index.
  localparam int                CNT_W    = (IFG_NIBBLES > 16) ? $clog2(IFG_NIBBLES) : 4;
  localparam logic [31:0]       CRC_POLY = 32'hEDB88320;
  localparam logic [31:0]       CRC_INIT = 32'hFFFFFFFF;
  localparam logic [10:0]       MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [10:0]       CNT_MAX  = 11'h7FF;
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0]  FCS_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAD  = 3'd3,
    FCS  = 3'd4,
    IFG  = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             hi, hi_nx;           // 0: low nibble cycle, 1: high nibble cycle
  logic [7:0]       byte_q, byte_nx;
  logic             last_q, last_nx;
  logic [10:0]      bytecount, bytecount_nx;
  logic [10:0]      count_inc;
  logic [31:0]      crc, crc_nx;
  logic [31:0]      fcs;
  logic [3:0]       data_nib;
  logic             txen_nx;
  logic [3:0]       txd_nx;
  logic             frame_done_nx;

  // Reflected CRC-32 advanced by one nibble, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Next-state, handshake and next-output decode.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    hi_nx         = hi;
    byte_nx       = byte_q;
    last_nx       = last_q;
    bytecount_nx  = bytecount;
    crc_nx        = crc;
    txen_nx       = 1'b0;
    txd_nx        = 4'h0;
    frame_done_nx = 1'b0;
    s_ready       = 1'b0;
    underrun      = 1'b0;
    busy          = (state != IDLE);
    fcs           = ~crc;
    count_inc     = (bytecount == CNT_MAX) ? bytecount : bytecount + 11'd1;
    data_nib      = hi ? byte_q[7:4] : byte_q[3:0];

    case (state)
      IDLE: begin
        crc_nx       = CRC_INIT;
        bytecount_nx = '0;
        cnt_nx       = '0;
        hi_nx        = 1'b0;
        if (s_valid) state_nx = PRE;
      end

      PRE: begin
        txen_nx = 1'b1;
        txd_nx  = (cnt == PRE_LAST) ? 4'hD : 4'h5;
        cnt_nx  = cnt + CNT_ONE;
        if (cnt == PRE_LAST) begin
          s_ready = 1'b1;
          cnt_nx  = '0;
          if (s_valid) begin
            byte_nx  = s_data;
            last_nx  = s_last;
            hi_nx    = 1'b0;
            state_nx = DATA;
          end else begin
            // Starved on the first byte: abandon before the SFD goes out.
            underrun = 1'b1;
            txen_nx  = 1'b0;
            txd_nx   = 4'h0;
            state_nx = IFG;
          end
        end
      end

      DATA: begin
        txen_nx = 1'b1;
        txd_nx  = data_nib;
        crc_nx  = crc_nib(crc, data_nib);
        hi_nx   = ~hi;
        if (hi) begin
          bytecount_nx = count_inc;
          if (last_q) begin
            hi_nx    = 1'b0;
            cnt_nx   = '0;
            state_nx = (count_inc < MIN_CNT) ? PAD : FCS;
          end else begin
            s_ready = 1'b1;
            if (s_valid) begin
              byte_nx = s_data;
              last_nx = s_last;
            end else begin
              // Starved mid-frame: drop txen so the receiver sees a bad FCS.
              underrun = 1'b1;
              txen_nx  = 1'b0;
              txd_nx   = 4'h0;
              cnt_nx   = '0;
              state_nx = IFG;
            end
          end
        end
      end

      PAD: begin
        txen_nx = 1'b1;
        txd_nx  = 4'h0;
        crc_nx  = crc_nib(crc, 4'h0);
        hi_nx   = ~hi;
        if (hi) begin
          bytecount_nx = count_inc;
          if (count_inc >= MIN_CNT) begin
            hi_nx    = 1'b0;
            cnt_nx   = '0;
            state_nx = FCS;
          end
        end
      end

      FCS: begin
        txen_nx = 1'b1;
        txd_nx  = fcs[{cnt[2:0], 2'b00} +: 4];
        cnt_nx  = cnt + CNT_ONE;
        if (cnt == FCS_LAST) begin
          frame_done_nx = 1'b1;
          cnt_nx        = '0;
          state_nx      = IFG;
        end
      end

      IFG: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt == IFG_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered MII outputs.
  always_ff @(posedge txc) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= 1'b0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      bytecount  <= '0;
      crc        <= CRC_INIT;
      txen       <= 1'b0;
      txd        <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      hi         <= hi_nx;
      byte_q     <= byte_nx;
      last_q     <= last_nx;
      bytecount  <= bytecount_nx;
      crc        <= crc_nx;
      txen       <= txen_nx;
      txd        <= txd_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mii_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mii_tx_framer
// Purpose  : Scoreboard bench for mii_tx_framer. Expected nibbles are queued
//            when a frame is issued; monitors pop and compare on every txen
//            cycle and collect frame timing (lengths, gaps, pulses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mii_tx_framer;

  typedef logic [7:0] byte_t;
  localparam int IFG = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_last, b_valid, b_last;
  logic       a_ready, a_txen, a_busy, a_fd, a_ur;
  logic       b_ready, b_txen, b_busy, b_fd, b_ur;
  logic [3:0] a_txd, b_txd;

  // Instance A pads to 60 bytes, instance B never pads.
  mii_tx_framer #(.MIN_PAYLOAD(60), .IFG_NIBBLES(IFG)) dut_a (
    .txc(clk), .rst_n(rst_n), .s_data(a_data), .s_valid(a_valid), .s_last(a_last),
    .s_ready(a_ready), .txen(a_txen), .txd(a_txd), .busy(a_busy),
    .frame_done(a_fd), .underrun(a_ur)
  );

  mii_tx_framer #(.MIN_PAYLOAD(0), .IFG_NIBBLES(IFG)) dut_b (
    .txc(clk), .rst_n(rst_n), .s_data(b_data), .s_valid(b_valid), .s_last(b_last),
    .s_ready(b_ready), .txen(b_txen), .txd(b_txd), .busy(b_busy),
    .frame_done(b_fd), .underrun(b_ur)
  );

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];

  // Per-instance timing observations gathered by the monitors.
  int run[2], low[2], last_run[2], gap[2], fd_pos[2], fd_n[2], ur_n[2], rdy_n[2];
  int since_fd[2], rise_after_fd[2], since_ur[2], busy_fall_ur[2];
  bit en_after_ur[2];
  bit busy_prev[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int s, input logic [3:0] n);
    if (s == 0) exp_a.push_back(n);
    else        exp_b.push_back(n);
  endtask

  task automatic push_pre(input int s);
    for (int i = 0; i < 15; i++) push(s, 4'h5);
    push(s, 4'hD);
  endtask

  // Byte-at-a-time reflected CRC-32 reference.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input byte_t b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Queue the full expected wire image of a frame: preamble, data, pad, FCS.
  task automatic push_frame(input int s, input byte_t p[$], input int minp);
    logic [31:0] c;
    byte_t       b;
    int          n;
    c = 32'hFFFFFFFF;
    push_pre(s);
    n = (p.size() < minp) ? minp : p.size();
    for (int i = 0; i < n; i++) begin
      b = (i < p.size()) ? p[i] : 8'h00;
      c = crc_byte(c, b);
      push(s, b[3:0]);
      push(s, b[7:4]);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) push(s, c[4*k +: 4]);
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] d, input logic l);
    if (s == 0) begin a_valid = v; a_data = d; a_last = l; end
    else        begin b_valid = v; b_data = d; b_last = l; end
  endtask

  function automatic logic ready_of(input int s);
    return (s == 0) ? a_ready : b_ready;
  endfunction

  // Called and returns at posedge+1; holds the byte until it is accepted.
  task automatic put_byte(input int s, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    drive(s, 1'b1, d, l);
    forever begin
      @(negedge clk);
      if (ready_of(s)) break;
      n++;
      if (n > 400) begin
        total++; bad++;
        $display("FAIL dut%0d handshake: actual=no s_ready required=s_ready within 400 cycles", s);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive(s, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input int s, input byte_t p[$]);
    for (int i = 0; i < p.size(); i++) put_byte(s, p[i], i == p.size() - 1);
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((s == 0) ? a_busy : b_busy) && n < 3000);
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL dut%0d idle wait: actual=busy required=idle within 3000 cycles", s);
    end
    @(posedge clk); #1;
    check($sformatf("dut%0d unconsumed nibbles", s),
          (s == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  task automatic wait_fd(input int s, input int start);
    int n;
    n = 0;
    while (fd_n[s] == start && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL dut%0d frame_done wait: actual=none required=pulse within 500 cycles", s);
    end
  endtask

  // Compares every txen nibble against the queue and records frame timing.
  task automatic monitor(input int s);
    logic       en, fd, ur, bs, rd;
    logic [3:0] nib, e;
    forever begin
      @(negedge clk);
      en  = (s == 0) ? a_txen  : b_txen;
      nib = (s == 0) ? a_txd   : b_txd;
      fd  = (s == 0) ? a_fd    : b_fd;
      ur  = (s == 0) ? a_ur    : b_ur;
      bs  = (s == 0) ? a_busy  : b_busy;
      rd  = (s == 0) ? a_ready : b_ready;
      since_fd[s] = (fd === 1'b1) ? 0 : since_fd[s] + 1;
      since_ur[s] = (ur === 1'b1) ? 0 : since_ur[s] + 1;
      if (ur === 1'b1) ur_n[s]++;
      if (rd === 1'b1) rdy_n[s]++;
      if (since_ur[s] == 1) en_after_ur[s] = (en === 1'b1);
      if (en === 1'b1) begin
        if (run[s] == 0) begin
          gap[s]           = low[s];
          rise_after_fd[s] = since_fd[s];
        end
        run[s]++;
        low[s] = 0;
        if ((s == 0 && exp_a.size() == 0) || (s == 1 && exp_b.size() == 0)) begin
          total++; bad++;
          $display("FAIL dut%0d nibble: actual=%0h required=none (txen unexpected)", s, nib);
        end else begin
          if (s == 0) e = exp_a.pop_front();
          else        e = exp_b.pop_front();
          check($sformatf("dut%0d nibble", s), {28'h0, nib}, {28'h0, e});
        end
      end else begin
        if (run[s] != 0) last_run[s] = run[s];
        run[s] = 0;
        low[s]++;
      end
      if (fd === 1'b1) begin
        fd_n[s]++;
        fd_pos[s] = run[s];
      end
      if (busy_prev[s] && bs === 1'b0) busy_fall_ur[s] = since_ur[s];
      busy_prev[s] = (bs === 1'b1);
    end
  endtask

  initial begin
    byte_t p[$];
    byte_t q[$];
    string str;
    int    f0, u0, r0;

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset txen",       a_txen,  0);
    check("reset txd",        a_txd,   0);
    check("reset s_ready",    a_ready, 0);
    check("reset busy",       a_busy,  0);
    check("reset frame_done", a_fd,    0);
    check("reset underrun",   a_ur,    0);
    check("reset b txen",     b_txen,  0);
    check("reset b busy",     b_busy,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Minimum frame: one byte padded to 60
    p = '{8'hAB};
    push_frame(0, p, 60);
    f0 = fd_n[0];
    @(posedge clk); #1;
    send(0, p);
    wait_idle(0);
    check("min frame txen cycles",  last_run[0],     144);
    check("min frame done cycle",   fd_pos[0],       144);
    check("min frame done pulses",  fd_n[0] - f0,    1);

    // 64-byte payload needs no padding
    p.delete();
    for (int i = 0; i < 64; i++) p.push_back(8'(i));
    push_frame(0, p, 60);
    send(0, p);
    wait_idle(0);
    check("nopad txen cycles", last_run[0], 152);
    check("nopad done cycle",  fd_pos[0],   152);

    // CRC check value on "123456789", then a back-to-back second frame
    str = "123456789";
    p.delete();
    for (int i = 0; i < str.len(); i++) p.push_back(str[i]);
    push_pre(1);
    for (int i = 0; i < p.size(); i++) begin
      push(1, p[i][3:0]);
      push(1, p[i][7:4]);
    end
    push(1, 4'h6); push(1, 4'h2); push(1, 4'h9); push(1, 4'h3);
    push(1, 4'h4); push(1, 4'hF); push(1, 4'hB); push(1, 4'hC);
    r0 = rdy_n[1];
    f0 = fd_n[1];
    send(1, p);
    check("crc frame s_ready cycles", rdy_n[1] - r0, 9);
    wait_fd(1, f0);
    check("crc frame txen cycles", fd_pos[1], 42);
    q = '{8'h01, 8'h02, 8'h03};
    push_frame(1, q, 0);
    send(1, q);
    wait_idle(1);
    check("b2b txen low cycles",         gap[1],           IFG + 1);
    check("b2b preamble after done",     rise_after_fd[1], 26);
    check("b2b second frame txen cycles", last_run[1],     30);

    // Underrun: byte 5 of a 20-byte frame never arrives
    push_pre(0);
    for (int i = 0; i < 4; i++) begin
      push(0, 4'h0 + 4'(i));
      push(0, 4'h1);
    end
    push(0, 4'h4);
    u0 = ur_n[0];
    f0 = fd_n[0];
    for (int i = 0; i < 5; i++) put_byte(0, 8'(8'h10 + i), 1'b0);
    wait_idle(0);
    check("underrun pulses",        ur_n[0] - u0,     1);
    check("underrun txen next",     en_after_ur[0],   0);
    check("underrun txen cycles",   last_run[0],      25);
    check("underrun idle after",    busy_fall_ur[0],  IFG + 1);
    check("underrun no frame_done", fd_n[0] - f0,     0);

    // Reset during DATA, then a clean frame
    p.delete();
    for (int i = 0; i < 10; i++) p.push_back(8'(8'hA0 + i));
    push_frame(0, p, 60);
    for (int i = 0; i < 4; i++) put_byte(0, p[i], 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset txen",       a_txen,  0);
    check("midreset txd",        a_txd,   0);
    check("midreset s_ready",    a_ready, 0);
    check("midreset busy",       a_busy,  0);
    check("midreset frame_done", a_fd,    0);
    check("midreset underrun",   a_ur,    0);
    exp_a.delete();
    @(posedge clk); #1;
    p = '{8'h5A, 8'hC3};
    push_frame(0, p, 60);
    send(0, p);
    wait_idle(0);
    check("post-reset txen cycles", last_run[0], 144);
    check("post-reset done cycle",  fd_pos[0],   144);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
